// File: rtl/mig_app_arbiter.sv
// mig_app_arbiter: shares the DDR3 MIG app_* interface between instruction fetch (IF) and data memory (DM).
// Optional one-line instruction buffer enabled by defining MIG_ARB_LINE_BUFFER_EN.
module mig_app_arbiter #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128
) (
  input  logic                          ui_clk,
  input  logic                          sys_rst,
  input  logic                          init_calib_complete,
  input  logic                          if_req,
  input  logic [31:0]                   if_addr,
  output logic                          if_ack,
  output logic                          if_rvalid,
  output logic [31:0]                   if_rdata,
  input  logic                          dm_req,
  input  logic                          dm_we,
  input  logic [31:0]                   dm_addr,
  input  logic [31:0]                   dm_wdata,
  output logic                          dm_ack,
  output logic                          dm_rvalid,
  output logic [31:0]                   dm_rdata,
  output logic                          dm_wdone,
  output logic [ADDR_WIDTH-1:0]         app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  input  logic                          app_rdy,
  output logic [APP_DATA_WIDTH-1:0]     app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0]   app_wdf_mask,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  input  logic                          app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]     app_rd_data,
  input  logic                          app_rd_data_valid,
  output logic [2:0]                    fsm_state
);

  typedef enum logic [2:0] {
    S_CALIB_WAIT = 3'd0,
    S_IDLE       = 3'd1,
    S_CMD        = 3'd2,
    S_WR         = 3'd3,
    S_RDWAIT     = 3'd4,
    S_HIT        = 3'd5
  } state_t;

  state_t state, state_n;

  logic        owner_if;   // current transaction belongs to the IF port
  logic        rr_if_pri;  // IF wins the next contention
  logic [31:0] addr_q;
  logic        cmd_done, wdf_done;

  logic        if_cand, dm_cand, contend;
  logic        grant_if, grant_dm;
  logic        cmd_acc, wdf_acc;
  logic        if_hit;
  logic [31:0] addr_n;
  logic [31:0] hit_word;
  logic [31:0] rd_word;
  logic [APP_DATA_WIDTH/8-1:0] mask_n;
  logic        unused_bits;

  // MIG handshakes: a command (app_en) or write beat (app_wdf_wren) transfers on the
  // rising edge where it is high together with its ready; it then stays high until that edge.
  always_comb begin
    if_cand  = if_req && !if_ack;
    dm_cand  = dm_req && !dm_ack;
    contend  = 1'b0;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    cmd_acc  = cmd_done || (app_en && app_rdy);
    wdf_acc  = wdf_done || (app_wdf_wren && app_wdf_rdy);
    state_n  = state;
    case (state)
      S_CALIB_WAIT: if (init_calib_complete) state_n = S_IDLE;
      S_IDLE: begin
        if (!init_calib_complete) begin
          state_n = S_CALIB_WAIT;
        end else begin
          if (if_cand && dm_cand) begin
            contend  = 1'b1;
            grant_if = rr_if_pri;
            grant_dm = !rr_if_pri;
          end else begin
            grant_if = if_cand;
            grant_dm = dm_cand;
          end
          if (grant_if) state_n = if_hit ? S_HIT : S_CMD;
          if (grant_dm) state_n = dm_we ? S_WR : S_CMD;
        end
      end
      S_CMD:    if (app_en && app_rdy) state_n = S_RDWAIT;
      S_WR:     if (cmd_acc && wdf_acc) state_n = S_IDLE;
      S_RDWAIT: if (app_rd_data_valid) state_n = S_IDLE;
      S_HIT:    state_n = S_IDLE;
      default:  state_n = S_CALIB_WAIT;
    endcase
  end

  always_comb begin
    addr_n = grant_dm ? dm_addr : if_addr;
    mask_n = '1;
    mask_n[{dm_addr[3:2], 2'b00} +: 4] = 4'b0000;
    rd_word = app_rd_data[{addr_q[3:2], 5'b00000} +: 32];
  end

  assign app_wdf_end = app_wdf_wren;
  assign fsm_state   = state;
  assign unused_bits = ^addr_q;

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_CALIB_WAIT;
    else         state <= state_n;
  end

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
      if_rvalid    <= 1'b0;
      dm_rvalid    <= 1'b0;
      dm_wdone     <= 1'b0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      app_addr     <= '0;
      app_cmd      <= '0;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_wdf_wren <= 1'b0;
      owner_if     <= 1'b0;
      rr_if_pri    <= 1'b0;
      addr_q       <= '0;
      cmd_done     <= 1'b0;
      wdf_done     <= 1'b0;
    end else begin
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_wdone  <= 1'b0;
      if (grant_if || grant_dm) begin
        if_ack   <= grant_if;
        dm_ack   <= grant_dm;
        owner_if <= grant_if;
        addr_q   <= addr_n;
        app_addr <= {addr_n[ADDR_WIDTH:4], 3'b000};
        app_cmd  <= (grant_dm && dm_we) ? 3'b000 : 3'b001;
        cmd_done <= 1'b0;
        wdf_done <= 1'b0;
        if (grant_dm && dm_we) begin
          app_wdf_data <= {(APP_DATA_WIDTH/32){dm_wdata}};
          app_wdf_mask <= mask_n;
        end
        if (contend) rr_if_pri <= grant_dm;
      end
      case (state)
        S_CMD: app_en <= !(app_en && app_rdy);
        S_WR: begin
          // command and write data complete independently, in either order
          if (app_en && app_rdy) begin
            app_en   <= 1'b0;
            cmd_done <= 1'b1;
          end else if (!cmd_done) begin
            app_en <= 1'b1;
          end
          if (app_wdf_wren && app_wdf_rdy) begin
            app_wdf_wren <= 1'b0;
            wdf_done     <= 1'b1;
          end else if (!wdf_done) begin
            app_wdf_wren <= 1'b1;
          end
          if (cmd_acc && wdf_acc) dm_wdone <= 1'b1;
        end
        S_RDWAIT: begin
          if (app_rd_data_valid) begin
            if (owner_if) begin
              if_rdata  <= rd_word;
              if_rvalid <= 1'b1;
            end else begin
              dm_rdata  <= rd_word;
              dm_rvalid <= 1'b1;
            end
          end
        end
        S_HIT: begin
          if_rdata  <= hit_word;
          if_rvalid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MIG_ARB_LINE_BUFFER_EN
  logic [APP_DATA_WIDTH-1:0] buf_line;
  logic [27:0]               buf_tag;
  logic                      buf_valid;

  assign if_hit   = buf_valid && (if_addr[31:4] == buf_tag);
  assign hit_word = buf_line[{addr_q[3:2], 5'b00000} +: 32];

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      buf_line  <= '0;
      buf_tag   <= '0;
      buf_valid <= 1'b0;
    end else if (state == S_RDWAIT && app_rd_data_valid && owner_if) begin
      buf_line  <= app_rd_data;
      buf_tag   <= addr_q[31:4];
      buf_valid <= 1'b1;
    end else if (grant_dm && dm_we && (dm_addr[31:4] == buf_tag)) begin
      buf_valid <= 1'b0;
    end
  end
`else
  assign if_hit   = 1'b0;
  assign hit_word = '0;
`endif

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Directed self-checking bench for mig_app_arbiter; line-buffer cases run when MIG_ARB_LINE_BUFFER_EN is defined.
module tb_mig_app_arbiter;

  logic         ui_clk;
  logic         sys_rst;
  logic         init_calib_complete;
  logic         if_req;
  logic [31:0]  if_addr;
  logic         if_ack;
  logic         if_rvalid;
  logic [31:0]  if_rdata;
  logic         dm_req;
  logic         dm_we;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic         dm_ack;
  logic         dm_rvalid;
  logic [31:0]  dm_rdata;
  logic         dm_wdone;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic [2:0]   fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;

  mig_app_arbiter dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_wdone(dm_wdone),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .fsm_state(fsm_state)
  );

  // clock / reset
  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!(if_ack || dm_ack) && n < 20) begin
      tick();
      n++;
    end
  endtask

  // MIG side of a read: accept the command, return the line after a short latency
  task automatic finish_read(input bit is_if, input logic [27:0] exp_addr,
                             input logic [127:0] line, input logic [31:0] exp_word);
    int n = 0;
    while (!app_en && n < 20) begin
      tick();
      n++;
    end
    check("rd_app_en", app_en, 1'b1);
    check("rd_app_cmd", app_cmd, 3'b001);
    check("rd_app_addr", app_addr, exp_addr);
    exp_q.push_back(exp_word);
    tick();
    check("rd_app_en_drop", app_en, 1'b0);
    repeat (2) tick();
    app_rd_data       = line;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    check(is_if ? "if_rvalid" : "dm_rvalid", is_if ? if_rvalid : dm_rvalid, 1'b1);
    check("other_rvalid", is_if ? dm_rvalid : if_rvalid, 1'b0);
    check(is_if ? "if_rdata" : "dm_rdata", is_if ? if_rdata : dm_rdata, exp_q.pop_front());
    tick();
    check("rvalid_pulse", if_rvalid || dm_rvalid, 1'b0);
  endtask

  task automatic do_read(input bit is_if, input logic [31:0] a, input logic [27:0] exp_addr,
                         input logic [127:0] line, input logic [31:0] exp_word);
    if (is_if) begin
      if_addr = a;
      if_req  = 1'b1;
    end else begin
      dm_addr = a;
      dm_we   = 1'b0;
      dm_req  = 1'b1;
    end
    wait_ack();
    check(is_if ? "if_ack" : "dm_ack", is_if ? if_ack : dm_ack, 1'b1);
    if_req = 1'b0;
    dm_req = 1'b0;
    finish_read(is_if, exp_addr, line, exp_word);
  endtask

  // write with app_wdf_rdy held low for 5 cycles after the command is taken
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [27:0] exp_addr,
                          input logic [15:0] exp_mask, input logic [127:0] exp_data);
    logic early_done = 1'b0;
    logic bad_hold   = 1'b0;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b0;
    dm_addr  = a;
    dm_wdata = d;
    dm_we    = 1'b1;
    dm_req   = 1'b1;
    wait_ack();
    check("wr_dm_ack", dm_ack, 1'b1);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();
    check("wr_app_en", app_en, 1'b1);
    check("wr_wren", app_wdf_wren, 1'b1);
    check("wr_end", app_wdf_end, 1'b1);
    check("wr_cmd", app_cmd, 3'b000);
    check("wr_addr", app_addr, exp_addr);
    check("wr_mask", app_wdf_mask, exp_mask);
    check("wr_data", app_wdf_data, exp_data);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dm_wdone) early_done = 1'b1;
      if (app_en || !app_wdf_wren) bad_hold = 1'b1;
    end
    check("wr_no_early_wdone", early_done, 1'b0);
    check("wr_en_drop_wren_hold", bad_hold, 1'b0);
    app_wdf_rdy = 1'b1;
    tick();
    app_wdf_rdy = 1'b0;
    check("wr_wdone", dm_wdone, 1'b1);
    check("wr_wren_drop", app_wdf_wren, 1'b0);
    tick();
    check("wr_wdone_pulse", dm_wdone, 1'b0);
  endtask

  task automatic contend(input bit exp_dm, input logic [127:0] line);
    if_addr = 32'h40;
    dm_addr = 32'h38;
    dm_we   = 1'b0;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    wait_ack();
    check("cont_dm_ack", dm_ack, exp_dm);
    check("cont_if_ack", if_ack, !exp_dm);
    if_req = 1'b0;
    dm_req = 1'b0;
    if (exp_dm) finish_read(1'b0, 28'h18, line, 32'h33333333);
    else        finish_read(1'b1, 28'h20, line, 32'h11111111);
  endtask

  initial begin
    logic seen;
    int   n;
    sys_rst = 1'b1;
    init_calib_complete = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    repeat (3) tick();
    check("rst_state", fsm_state, 3'd0);
    check("rst_app_en", app_en, 1'b0);
    check("rst_app_addr", app_addr, 28'h0);
    check("rst_acks", {if_ack, dm_ack, if_rvalid, dm_rvalid, dm_wdone, app_wdf_wren}, 6'b0);
    sys_rst = 1'b0;

    // calibration gate
    if_addr = 32'h20;
    if_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (if_ack || app_en) seen = 1'b1;
    end
    check("calib_gate", seen, 1'b0);
    check("calib_state", fsm_state, 3'd0);
    init_calib_complete = 1'b1;
    n = 0;
    while (!if_ack && n < 20) begin
      tick();
      n++;
    end
    check("calib_ack", if_ack, 1'b1);
    check("calib_ack_lat", n, 2);
    if_req = 1'b0;
    tick();
    check("calib_en_after_ack", app_en, 1'b1);
    finish_read(1'b1, 28'h10, LINE_A, 32'h11111111);

    // read word select
    do_read(1'b0, 32'h1C, 28'h8, LINE_A, 32'h44444444);

    // partial write, staggered ready
    do_write(32'h24, 32'hDEADBEEF, 28'h10, 16'hFF0F, {4{32'hDEADBEEF}});

    // contention: DM, IF, DM
    contend(1'b1, LINE_A);
    contend(1'b0, LINE_A);
    contend(1'b1, LINE_A);

    // reset in RDWAIT, then a late read return
    dm_addr = 32'h10;
    dm_we   = 1'b0;
    dm_req  = 1'b1;
    wait_ack();
    dm_req = 1'b0;
    n = 0;
    while (!app_en && n < 20) begin
      tick();
      n++;
    end
    tick();
    check("mid_rdwait", fsm_state, 3'd4);
    sys_rst = 1'b1;
    #1;
    check("mid_rst_state", fsm_state, 3'd0);
    check("mid_rst_outs", {app_en, app_wdf_wren, dm_ack, dm_rvalid, app_cmd}, 7'b0);
    check("mid_rst_addr", app_addr, 28'h0);
    tick();
    sys_rst = 1'b0;
    app_rd_data = LINE_A;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (if_rvalid || dm_rvalid) seen = 1'b1;
      tick();
    end
    check("late_valid_ignored", seen, 1'b0);

`ifdef MIG_ARB_LINE_BUFFER_EN
    do_read(1'b1, 32'h100, 28'h80, LINE_B, 32'hA0A0A0A0);
    if_addr = 32'h104;
    if_req  = 1'b1;
    seen = 1'b0;
    wait_ack();
    check("hit_ack", if_ack, 1'b1);
    if (app_en) seen = 1'b1;
    if_req = 1'b0;
    tick();
    if (app_en) seen = 1'b1;
    check("hit_rvalid", if_rvalid, 1'b1);
    check("hit_rdata", if_rdata, 32'hA0A0A0A1);
    tick();
    if (app_en) seen = 1'b1;
    check("hit_no_mig", seen, 1'b0);
    do_write(32'h108, 32'h12345678, 28'h80, 16'hF0FF, {4{32'h12345678}});
    do_read(1'b1, 32'h100, 28'h80, LINE_A, 32'h11111111);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mig_app_arbiter.md
# mig_app_arbiter

Arbiter and sequencer for the DDR3 MIG user (app_*) interface, shared between the instruction-fetch port and the data-memory port of the core. Each port issues 32-bit word requests on byte addresses; the arbiter maps them onto 128-bit MIG bursts and drives the command and write-data handshakes. It also extracts the read word from the returned line and builds the byte mask for partial writes. It sits in the ui_clk domain between the core and `ExternalMemory`, and allows one outstanding MIG transaction at a time.

## Interface
- `ADDR_WIDTH`, 28: MIG app_addr width.
- `APP_DATA_WIDTH`, 128: MIG data width (one burst line = 16 bytes).
- `ui_clk` in 1: MIG UI clock; all logic on rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `init_calib_complete` in 1: MIG calibration done.
- `if_req` in 1, `if_addr` in 32: instruction-fetch read request and byte address.
- `if_ack` out 1: request accepted, one-cycle pulse.
- `if_rvalid` out 1, `if_rdata` out 32: fetch data, one-cycle pulse.
- `dm_req` in 1, `dm_we` in 1, `dm_addr` in 32, `dm_wdata` in 32: data-memory request; `dm_we`=1 selects a write.
- `dm_ack` out 1: data request accepted.
- `dm_rvalid` out 1, `dm_rdata` out 32: data read response.
- `dm_wdone` out 1: write data and command both accepted by MIG.
- `app_addr` out ADDR_WIDTH, `app_cmd` out 3 (000 write, 001 read), `app_en` out 1.
- `app_rdy` in 1.
- `app_wdf_data` out 128, `app_wdf_mask` out 16, `app_wdf_wren` out 1, `app_wdf_end` out 1.
- `app_wdf_rdy` in 1.
- `app_rd_data` in 128, `app_rd_data_valid` in 1.

## Operation
- Address map: `app_addr = {addr[ADDR_WIDTH:4], 3'b000}`, where `addr` is the latched byte address. Word select is `addr[3:2]`; word k occupies `app_rd_data[32k+31:32k]`.
- Write: `dm_wdata` is replicated into all four word lanes. `app_wdf_mask` is all ones except bits `[4k+3:4k]`, which are zero for k = `dm_addr[3:2]`. `app_wdf_end` equals `app_wdf_wren`.
- States:
  - CALIB_WAIT: waits for `init_calib_complete`, then goes to IDLE.
  - IDLE: arbitrates the pending requests.
  - CMD: holds `app_en` until `app_rdy`.
  - WR: holds `app_en`/`app_wdf_wren` until both are accepted.
  - RDWAIT: waits for `app_rd_data_valid`.
- IDLE arbitration:
  - If only one port requests, that port is granted.
  - If both request, round-robin is used, with the port that lost the last contention winning. After reset, DM has priority.
  - On grant, the address/we/data are latched and the corresponding `*_ack` pulses in the same cycle.
  - A read grant goes to CMD. A write grant goes to WR.
- CMD: the cycle in which `app_en && app_rdy` is true moves to RDWAIT.
- WR: the command and the write data are tracked by independent accepted flags. `app_en` drops the cycle after `app_rdy`; `app_wdf_wren` drops the cycle after `app_wdf_rdy`. Once both are done, `dm_wdone` pulses and the FSM returns to IDLE.
- RDWAIT: on `app_rd_data_valid`, the selected word is driven on `if_rdata` or `dm_rdata` with a one-cycle `*_rvalid`, and the FSM returns to IDLE.
- `app_rd_data_valid` outside RDWAIT is ignored. This covers stale data after a reset.
- If `init_calib_complete` falls while in IDLE, the FSM goes to CALIB_WAIT. In any other state the current transaction completes first.
- Reset: FSM → CALIB_WAIT; all strobes, acks, valids, `app_en`, and `app_wdf_wren` → 0; data/address outputs → 0; round-robin pointer → DM.

## Timing
- Request to ack: 1 cycle in IDLE (same-cycle grant, registered ack on the next edge).
- `app_en` asserts the cycle after ack.
- Read latency is the MIG latency plus 1 cycle: `*_rvalid` is registered on the edge after `app_rd_data_valid`.
- Requesters hold `req`/`addr`/`data` stable until `*_ack`. Dropping `req` before ack withdraws the request.
- Minimum IDLE→IDLE turnaround is 3 cycles, with no back-to-back grants.

## Configuration
- `MIG_ARB_LINE_BUFFER_EN` defined:
  - A one-line instruction buffer is enabled: a 128-bit line, a tag `addr[31:4]`, and a valid bit.
  - Each IF read refills the buffer.
  - An IF request that hits the buffer in IDLE is acked, and `if_rvalid` follows 1 cycle later with no MIG access.
  - A DM write to the buffered line clears the valid bit. Reset also clears it.
- Macro not defined: every IF request goes to MIG.

## Test plan
- Calibration gate: `if_req` held with `init_calib_complete`=0 for 50 cycles → no `if_ack` and no `app_en`. After calibration rises → ack, then `app_cmd`=001 with `app_addr`=0x0000010 for `if_addr`=0x20.
- Read word select: `dm_addr`=0x1C, MIG returns `app_rd_data`=0x44444444_33333333_22222222_11111111 → `dm_rdata`=0x44444444, with `dm_rvalid` one cycle after valid.
- Partial write with staggered ready: `dm_addr`=0x24, `dm_wdata`=0xDEADBEEF → `app_wdf_mask`=0xFF0F. `app_wdf_rdy` is held low 5 cycles after `app_rdy` → `dm_wdone` only after both are accepted.
- Contention: `if_req` and `dm_req` assert together three times → grant order DM, IF, DM.
- Reset mid-read: `sys_rst` pulses in RDWAIT, then a late `app_rd_data_valid` arrives → no `*_rvalid`. Outputs are 0 and the FSM is in CALIB_WAIT.
- Line buffer (`MIG_ARB_LINE_BUFFER_EN`):
  - Fetch 0x100, then fetch 0x104 → the second fetch produces no `app_en` and its `if_rvalid` follows 1 cycle after ack.
  - DM write to 0x108, then fetch 0x100 → MIG read issued.
